muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 216 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: pipelined multiplier plus radix-2 restoring divider.
// Define MULDIV_DIV_FASTPATH_EN to let trivial divides skip the iteration phase.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 6
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  rs1_value_i,
  input  logic [XLEN-1:0]  rs2_value_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             wb_valid_o,
  output logic [XLEN-1:0]  wb_value_o,
  output logic [TAG_W-1:0] wb_tag_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } div_state_e;

  div_state_e state_q, state_d;

  logic accept;
  logic mul_acc;
  logic div_acc;

  assign req_ready_o = !reset_i && (state_q == IDLE);
  assign accept      = req_valid_i && req_ready_o && !flush_i;
  assign mul_acc     = accept && !funct3_i[2];
  assign div_acc     = accept && funct3_i[2];

  // ---------------- multiply ----------------
  logic              a_sgn;
  logic              b_sgn;
  logic [2*XLEN-1:0] pa;
  logic [2*XLEN-1:0] pb;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;

  assign a_sgn   = funct3_i[1:0] != 2'b11;
  assign b_sgn   = !funct3_i[1];
  assign pa      = {{XLEN{a_sgn & rs1_value_i[XLEN-1]}}, rs1_value_i};
  assign pb      = {{XLEN{b_sgn & rs2_value_i[XLEN-1]}}, rs2_value_i};
  assign prod    = pa * pb;
  assign mul_res = (funct3_i[1:0] == 2'b00) ? prod[XLEN-1:0]
                                            : prod[2*XLEN-1:XLEN];

  logic             mul_v;
  logic             mul_busy;
  logic [XLEN-1:0]  mul_val;
  logic [TAG_W-1:0] mul_tag;

  if (MUL_STAGES == 1) begin : g_mul_comb
    assign mul_v    = mul_acc;
    assign mul_busy = 1'b0;
    assign mul_val  = mul_res;
    assign mul_tag  = tag_i;
  end else begin : g_mul_pipe
    logic [MUL_STAGES-2:0] sv;
    logic [XLEN-1:0]       sr [MUL_STAGES-1];
    logic [TAG_W-1:0]      st [MUL_STAGES-1];

    always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) begin
        sv <= '0;
      end else begin
        sv[0] <= mul_acc;
        for (int i = 1; i < MUL_STAGES - 1; i++) sv[i] <= sv[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      sr[0] <= mul_res;
      st[0] <= tag_i;
      for (int i = 1; i < MUL_STAGES - 1; i++) begin
        sr[i] <= sr[i-1];
        st[i] <= st[i-1];
      end
    end

    assign mul_v    = sv[MUL_STAGES-2];
    assign mul_busy = |sv;
    assign mul_val  = sr[MUL_STAGES-2];
    assign mul_tag  = st[MUL_STAGES-2];
  end

  // ---------------- divide ----------------
  logic             div_sgn;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic             fast_hit;
  logic [XLEN-1:0]  abs_a;
  logic [XLEN-1:0]  abs_b;

  assign div_sgn = !funct3_i[0];
  assign a_neg   = div_sgn & rs1_value_i[XLEN-1];
  assign b_neg   = div_sgn & rs2_value_i[XLEN-1];
  assign b_zero  = rs2_value_i == '0;
  assign abs_a   = a_neg ? -rs1_value_i : rs1_value_i;
  assign abs_b   = b_neg ? -rs2_value_i : rs2_value_i;

`ifdef MULDIV_DIV_FASTPATH_EN
  assign fast_hit = b_zero
                 || (rs2_value_i == XLEN'(1))
                 || (div_sgn
                     && (rs1_value_i == {1'b1, {(XLEN-1){1'b0}}})
                     && (&rs2_value_i));
`else
  assign fast_hit = 1'b0;
`endif

  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             negq_q;
  logic             negr_q;
  logic             rem_op_q;
  logic [TAG_W-1:0] tag_q;

  logic [XLEN:0]    shl;
  logic [XLEN:0]    diff;
  logic             q_bit;
  logic [XLEN-1:0]  rem_nxt;

  assign shl     = {rem_q, quo_q[XLEN-1]};
  assign diff    = shl - {1'b0, dvs_q};
  assign q_bit   = !diff[XLEN];
  assign rem_nxt = q_bit ? diff[XLEN-1:0] : shl[XLEN-1:0];

  always_ff @(posedge clk_i) begin
    if (div_acc) begin
      dvs_q    <= abs_b;
      cnt_q    <= '0;
      // zero divisor keeps an all-ones quotient regardless of operand signs
      negq_q   <= (a_neg ^ b_neg) & !b_zero;
      negr_q   <= a_neg;
      rem_op_q <= funct3_i[1];
      tag_q    <= tag_i;
      if (fast_hit) begin
        quo_q <= b_zero ? '1 : abs_a;
        rem_q <= b_zero ? abs_a : '0;
      end else begin
        quo_q <= abs_a;
        rem_q <= '0;
      end
    end else if (state_q == ITER) begin
      quo_q <= {quo_q[XLEN-2:0], q_bit};
      rem_q <= rem_nxt;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  logic            div_done;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] div_res;

  // a divide never overtakes or collides with an older multiply
  assign div_done = (state_q == FIX) && !mul_busy;
  assign q_fix    = negq_q ? -quo_q : quo_q;
  assign r_fix    = negr_q ? -rem_q : rem_q;
  assign div_res  = rem_op_q ? r_fix : q_fix;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (div_acc) state_d = fast_hit ? FIX : ITER;
      ITER:    if (cnt_q == LAST) state_d = FIX;
      FIX:     if (!mul_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---------------- writeback ----------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wb_valid_o <= 1'b0;
      wb_value_o <= '0;
      wb_tag_o   <= '0;
    end else begin
      wb_valid_o <= !flush_i && (mul_v || div_done);
      if (mul_v) begin
        wb_value_o <= mul_val;
        wb_tag_o   <= mul_tag;
      end else if (div_done) begin
        wb_value_o <= div_res;
        wb_tag_o   <= tag_q;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i) assert (!(mul_v && div_done));
  end
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus
// hand sequences for back-to-back, busy hold, flush and reset.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam int MS   = 2;
  localparam int TW   = 6;
  localparam int SL   = XLEN + 2;
`ifdef MULDIV_DIV_FASTPATH_EN
  localparam int FL = 2;
`else
  localparam int FL = XLEN + 2;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      f3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [TW-1:0]   tag;
  logic            wb_valid;
  logic [XLEN-1:0] wb_value;
  logic [TW-1:0]   wb_tag;

  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MS), .TAG_W(TW)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .flush_i    (flush),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .funct3_i   (f3),
    .rs1_value_i(a),
    .rs2_value_i(b),
    .tag_i      (tag),
    .wb_valid_o (wb_valid),
    .wb_value_o (wb_value),
    .wb_tag_o   (wb_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 23;
  vec_t vt [NV];

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Called in the cycle after an accept edge; returns offset of wb cycle.
  task automatic wait_wb(input int limit, output int lat, output int early);
    lat   = -1;
    early = 0;
    for (int k = 1; k <= limit; k++) begin
      if (wb_valid) begin
        lat = k;
        break;
      end
      if (req_ready) early++;
      tick();
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [TW-1:0] t);
    req_valid = 1'b1;
    f3        = f;
    a         = x;
    b         = y;
    tag       = t;
  endtask

  initial begin
    int lat;
    int early;
    int cnt;

    vt[0]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MS};
    vt[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MS};
    vt[2]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MS};
    vt[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MS};
    vt[4]  = '{3'b000, 32'h00000007, 32'h00000006, 32'h0000002A, MS};
    vt[5]  = '{3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, MS};
    vt[6]  = '{3'b011, 32'h80000000, 32'h00000002, 32'h00000001, MS};
    vt[7]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, SL};
    vt[8]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, SL};
    vt[9]  = '{3'b101, 32'h00000064, 32'h00000000, 32'hFFFFFFFF, FL};
    vt[10] = '{3'b110, 32'h00001234, 32'h00000000, 32'h00001234, FL};
    vt[11] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, FL};
    vt[12] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, FL};
    vt[13] = '{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, FL};
    vt[14] = '{3'b111, 32'h00000064, 32'h00000007, 32'h00000002, SL};
    vt[15] = '{3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, SL};
    vt[16] = '{3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, SL};
    vt[17] = '{3'b100, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h00000008, SL};
    vt[18] = '{3'b100, 32'hFFFFFFFA, 32'h00000001, 32'hFFFFFFFA, FL};
    vt[19] = '{3'b100, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, FL};
    vt[20] = '{3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, FL};
    vt[21] = '{3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, FL};
    vt[22] = '{3'b100, 32'h00000064, 32'h00000007, 32'h0000000E, SL};

    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    f3        = '0;
    a         = '0;
    b         = '0;
    tag       = '0;
    tick();
    tick();
    chk("reset_ready", req_ready, 0);
    chk("reset_wbv", wb_valid, 0);
    chk("reset_val", wb_value, 0);
    chk("reset_tag", wb_tag, 0);
    reset = 1'b0;
    #1;
    chk("post_reset_ready", req_ready, 1);

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].f3, vt[i].a, vt[i].b, TW'(i + 1));
      chk($sformatf("v%0d_ready", i), req_ready, 1);
      tick();
      req_valid = 1'b0;
      wait_wb(60, lat, early);
      chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
      if (lat > 0) begin
        chk($sformatf("v%0d_val", i), wb_value, vt[i].exp);
        chk($sformatf("v%0d_tag", i), wb_tag, TW'(i + 1));
        chk($sformatf("v%0d_rdy_wb", i), req_ready, 1);
        if (vt[i].f3[2]) chk($sformatf("v%0d_busy", i), early, 0);
      end
      tick();
      chk($sformatf("v%0d_pulse", i), wb_valid, 0);
    end

    // ---- back-to-back multiplies ----
    drive(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd5);
    tick();
    drive(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd6);
    tick();
    req_valid = 1'b0;
    chk("b2b_v0", wb_valid, 1);
    chk("b2b_val0", wb_value, 32'h00000001);
    chk("b2b_tag0", wb_tag, 6'd5);
    tick();
    chk("b2b_v1", wb_valid, 1);
    chk("b2b_val1", wb_value, 32'hFFFFFFFE);
    chk("b2b_tag1", wb_tag, 6'd6);
    tick();
    chk("b2b_end", wb_valid, 0);

    // ---- request held through a busy divide ----
    drive(3'b100, 32'hFFFFFFF9, 32'h00000002, 6'd10);
    tick();
    drive(3'b101, 32'h00000064, 32'h00000007, 6'd11);
    wait_wb(60, lat, early);
    chk("hold_lat", lat, SL);
    chk("hold_busy", early, 0);
    chk("hold_val", wb_value, 32'hFFFFFFFD);
    chk("hold_tag", wb_tag, 6'd10);
    chk("hold_rdy", req_ready, 1);
    tick();
    req_valid = 1'b0;
    wait_wb(60, lat, early);
    chk("hold2_lat", lat, SL);
    chk("hold2_val", wb_value, 32'h0000000E);
    chk("hold2_tag", wb_tag, 6'd11);
    tick();

    // ---- flush during divide iteration ----
    drive(3'b000, 32'h3, 32'h4, 6'd20);
    tick();
    drive(3'b101, 32'h64, 32'h7, 6'd21);
    chk("fl_rdy1", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("fl_mul_v", wb_valid, 1);
    chk("fl_mul_val", wb_value, 32'hC);
    chk("fl_mul_tag", wb_tag, 6'd20);
    tick();
    tick();
    tick();
    chk("fl_busy", req_ready, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_rdy6", req_ready, 1);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (wb_valid) cnt++;
      tick();
    end
    chk("fl_no_wb", cnt, 0);

    // ---- flush drops a new request and a multiply in flight ----
    drive(3'b000, 32'h3, 32'h4, 6'd22);
    flush = 1'b1;
    tick();
    drive(3'b000, 32'h5, 32'h4, 6'd23);
    flush = 1'b0;
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (wb_valid) cnt++;
      tick();
    end
    chk("fl_drop", cnt, 0);

    // ---- reset mid-iteration ----
    drive(3'b100, 32'h64, 32'h7, 6'd30);
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1;
    #1;
    chk("rst_rdy_low", req_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_wbv", wb_valid, 0);
    chk("rst_val", wb_value, 0);
    chk("rst_tag", wb_tag, 0);
    chk("rst_rdy", req_ready, 1);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (wb_valid) cnt++;
      tick();
    end
    chk("rst_no_wb", cnt, 0);
    drive(3'b011, 32'h2, 32'h3, 6'd7);
    tick();
    req_valid = 1'b0;
    wait_wb(10, lat, early);
    chk("rst_mul_lat", lat, MS);
    chk("rst_mul_val", wb_value, 32'h0);
    chk("rst_mul_tag", wb_tag, 6'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
